// File: rtl/cache_pkg.sv
// Shared types for the memory port arbiter.
//   arbiter_state_t : arbiter FSM encoding
//   store_width_t   : store access size (byte/half/word)
//   cnt_w()         : width of an outstanding-transaction counter
package cache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef logic [1:0] store_width_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arbiter_state_t;

  // Needs to hold the value max itself, hence the extra bit.
  function automatic int unsigned cnt_w(input int unsigned max);
    return 32'($clog2(max)) + 32'd1;
  endfunction

endpackage

// File: rtl/memory_port_arbiter_counter.sv
// Outstanding-transaction counter.
//   inc_i   : a request was forwarded this cycle
//   dec_i   : a response arrived this cycle (ignored when empty)
//   count_o : current in-flight count
//   full_o  : count == MAX, empty_o : count == 0
module outstanding_counter
  import cache_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    inc_i,
  input  logic                    dec_i,
  output logic [cnt_w(MAX)-1:0]   count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned CW = cnt_w(MAX);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          inc_ok;
  logic          dec_ok;

  assign full_o  = (count_q == CW'(MAX));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Stray responses at zero are dropped so the count never underflows.
  always_comb begin
    inc_ok  = inc_i & ~full_o;
    dec_ok  = dec_i & ~empty_o;
    count_d = count_q;
    if (inc_ok && !dec_ok) begin
      count_d = count_q + CW'(1);
    end else if (dec_ok && !inc_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Two-master arbiter for a single memory load/store port.
//   access_req_i / stall_o : per-master ownership handshake
//   m_load_* / m_store_*   : per-master channels (owner muxed to memory)
//   load_* / store_*       : memory-side channels
// Ownership is held while the owner requests; on release the arbiter
// drains in-flight loads/stores before re-arbitrating (round-robin ties).
module memory_port_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [1:0]                   access_req_i,
  output logic [1:0]                   stall_o,
  input  logic [1:0]                   m_load_request_i,
  input  logic [1:0][ADDR_W-1:0]       m_load_address_i,
  input  logic [1:0]                   m_load_invalidate_i,
  output logic [1:0][DATA_W-1:0]       m_load_data_o,
  output logic [1:0]                   m_load_valid_o,
  input  logic [1:0]                   m_store_request_i,
  input  logic [1:0][ADDR_W-1:0]       m_store_address_i,
  input  logic [1:0][DATA_W-1:0]       m_store_data_i,
  input  store_width_t [1:0]           m_store_width_i,
  output logic [1:0]                   m_store_done_o,
  output logic                         load_request_o,
  output logic [ADDR_W-1:0]            load_address_o,
  output logic                         load_invalidate_o,
  input  logic [DATA_W-1:0]            load_data_i,
  input  logic                         load_valid_i,
  output logic                         store_request_o,
  output logic [ADDR_W-1:0]            store_address_o,
  output logic [DATA_W-1:0]            store_data_o,
  output store_width_t                 store_width_o,
  input  logic                         store_done_i
);

  localparam int unsigned CNT_W = cnt_w(MAX_OUTSTANDING);

  arbiter_state_t state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_owner_q, last_owner_d;

  logic [CNT_W-1:0] load_cnt, store_cnt;
  logic load_full, load_empty, store_full, store_empty;
  logic any_full;
  logic inflight;

  assign any_full = load_full | store_full;
  assign inflight = (load_cnt != '0) || (store_cnt != '0);

  outstanding_counter #(.MAX(MAX_OUTSTANDING)) u_load_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (load_request_o),
    .dec_i   (load_valid_i),
    .count_o (load_cnt),
    .full_o  (load_full),
    .empty_o (load_empty)
  );

  outstanding_counter #(.MAX(MAX_OUTSTANDING)) u_store_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (store_request_o),
    .dec_i   (store_done_i),
    .count_o (store_cnt),
    .full_o  (store_full),
    .empty_o (store_empty)
  );

  // Next-state, grant and channel muxing.
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_owner_d      = last_owner_q;
    stall_o           = 2'b11;
    load_request_o    = 1'b0;
    load_address_o    = '0;
    load_invalidate_o = 1'b0;
    store_request_o   = 1'b0;
    store_address_o   = '0;
    store_data_o      = '0;
    store_width_o     = '0;
    m_load_data_o     = '0;
    m_load_valid_o    = '0;
    m_store_done_o    = '0;

    unique case (state_q)
      IDLE: begin
        if (|access_req_i) begin
          // Both requesting: alternate away from the previous winner.
          owner_d      = (&access_req_i) ? ~last_owner_q : access_req_i[1];
          last_owner_d = owner_d;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        // Stall the owner (and mask its requests) while a counter is full.
        stall_o[owner_q]  = any_full;
        load_request_o    = m_load_request_i[owner_q] & ~any_full;
        load_address_o    = m_load_address_i[owner_q];
        load_invalidate_o = m_load_invalidate_i[owner_q];
        store_request_o   = m_store_request_i[owner_q] & ~any_full;
        store_address_o   = m_store_address_i[owner_q];
        store_data_o      = m_store_data_i[owner_q];
        store_width_o     = m_store_width_i[owner_q];
        if (!access_req_i[owner_q]) begin
          state_d = inflight ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (!inflight) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Responses go to the owner only; untracked responses are dropped.
    m_load_valid_o[owner_q] = load_valid_i & ~load_empty;
    if (load_valid_i && !load_empty) begin
      m_load_data_o[owner_q] = load_data_i;
    end
    m_store_done_o[owner_q] = store_done_i & ~store_empty;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule
